pc_sequencer: RTL

// Program-counter and run-control stage feeding instruction fetch of top_level.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_lut.sv | 19 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer:
// run-control states and the absolute branch target table.
package pc_pkg;
  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 4;
  localparam int LUT_DEPTH     = 2 ** LUT_IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [PC_W_DEF-1:0] lut_entry_t;

  // Entry k is the absolute PC loaded when a branch selects index k.
  localparam lut_entry_t BRANCH_LUT [LUT_DEPTH] = '{
    10'd0,   10'd12,  10'd20,  10'd40,
    10'd64,  10'd100, 10'd128, 10'd200,
    10'd256, 10'd300, 10'd384, 10'd512,
    10'd600, 10'd768, 10'd900, 10'd1023
  };

  function automatic lut_entry_t lut_lookup(input logic [LUT_IDX_W_DEF-1:0] idx);
    return BRANCH_LUT[idx];
  endfunction
endpackage

// File: rtl/pc_lut.sv
// Combinational branch target ROM: maps a target index to an absolute PC.
module pc_lut
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]      target
);

  lut_entry_t entry_s;

  always_comb begin
    entry_s = lut_lookup(LUT_IDX_W_DEF'(target_idx));
    target  = PC_W'(entry_s);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control: start on init, step or branch the PC each
// cycle, finish on halt or watchdog expiry.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
  parameter int START_ADDR = 0,
  parameter int MAX_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done,
  output logic                 timeout
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [31:0]     WD_LIMIT = 32'(MAX_CYCLES - 1);
  localparam logic            WD_EN    = (MAX_CYCLES != 0);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     count_q;
  logic            running_q;
  logic            done_q;
  logic            timeout_q;
  logic [PC_W-1:0] lut_target_s;
  logic            wd_hit_s;

  pc_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .target_idx (target_idx),
    .target     (lut_target_s)
  );

  // Next PC when RUN advances; >= keeps the watchdog firing if a stall skips the limit.
  always_comb begin
    if (branch_en) begin
      pc_d = lut_target_s;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
    wd_hit_s = WD_EN && (count_q >= WD_LIMIT);
  end

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      count_q   <= 32'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (init) begin
            state_q   <= RUN;
            pc_q      <= START_PC;
            count_q   <= 32'd0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          count_q <= count_q + 32'd1;
          if (stall) begin
            state_q <= RUN;
          end else if (wd_hit_s || halt) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= wd_hit_s;
          end else begin
            pc_q <= pc_d;
          end
        end
        DONE: begin
          // init must drop before a new start is accepted.
          if (!init) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule
